// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB transaction-layer encodings and usb_epsched state codes
package usb_pkg;

    localparam logic [1:0] REQ_OK      = 2'd0;
    localparam logic [1:0] REQ_ACTIVE  = 2'd1;
    localparam logic [1:0] REQ_FAIL    = 2'd2;

    localparam logic [1:0] REPLY_ACK   = 2'd0;
    localparam logic [1:0] REPLY_NAK   = 2'd1;
    localparam logic [1:0] REPLY_STALL = 2'd2;

    localparam logic [1:0] TYPE_SETUP  = 2'd0;
    localparam logic [1:0] TYPE_OUT    = 2'd1;
    localparam logic [1:0] TYPE_IN     = 2'd2;

    localparam logic [1:0] EPS_IDLE    = 2'd0;
    localparam logic [1:0] EPS_DECODE  = 2'd1;
    localparam logic [1:0] EPS_ACTIVE  = 2'd2;
    localparam logic [1:0] EPS_DONE    = 2'd3;

endpackage

// File: rtl/usb_epsched_if.sv
// rtl/usb_epsched_if.sv - transaction-layer handshake between link layer and endpoint scheduler
interface usb_epsched_if;

    logic [1:0] trsac_req;
    logic [1:0] trsac_type;
    logic [3:0] trsac_ep;
    logic [1:0] trsac_reply;
    logic       trsac_toggle;

    modport master (
        output trsac_req, trsac_type, trsac_ep,
        input  trsac_reply, trsac_toggle
    );

    modport slave (
        input  trsac_req, trsac_type, trsac_ep,
        output trsac_reply, trsac_toggle
    );

endinterface

// File: rtl/usb_eptoggle.sv
// rtl/usb_eptoggle.sv - per-endpoint IN/OUT data-toggle register file; clears beat flip/set
module usb_eptoggle #(
    parameter int EP_NUM = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_all,
    input  logic [EP_NUM-1:0] flip_in,
    input  logic [EP_NUM-1:0] flip_out,
    input  logic              set_ep0,
    input  logic [EP_NUM-1:0] clr,
    output logic [EP_NUM-1:0] in_tgl,
    output logic [EP_NUM-1:0] out_tgl
);

    logic [EP_NUM-1:0] in_tgl_q, in_tgl_d;
    logic [EP_NUM-1:0] out_tgl_q, out_tgl_d;

    always_comb begin
        in_tgl_d  = in_tgl_q ^ flip_in;
        out_tgl_d = out_tgl_q ^ flip_out;
        if (set_ep0) begin
            in_tgl_d[0]  = 1'b1;
            out_tgl_d[0] = 1'b1;
        end
        in_tgl_d  = in_tgl_d & ~clr;
        out_tgl_d = out_tgl_d & ~clr;
        if (clr_all) begin
            in_tgl_d  = '0;
            out_tgl_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_tgl_q  <= '0;
            out_tgl_q <= '0;
        end else begin
            in_tgl_q  <= in_tgl_d;
            out_tgl_q <= out_tgl_d;
        end
    end

    assign in_tgl  = in_tgl_q;
    assign out_tgl = out_tgl_q;

endmodule

// File: rtl/usb_epsched.sv
// rtl/usb_epsched.sv - USB endpoint scheduler: reply/toggle decode and handler routing; USB_EPSCHED_ISO_EN enables isochronous endpoints
module usb_epsched
    import usb_pkg::*;
#(
    parameter int          EP_NUM   = 16,
    parameter logic [15:0] ISO_MASK = 16'h0000
) (
    input  logic              clk,
    input  logic              rst0_async,
    input  logic              rst0_sync,
    usb_epsched_if.slave      trsac,
    input  logic [15:0]       togglebit_rst,
    input  logic [EP_NUM-1:0] ep_ready,
    input  logic [EP_NUM-1:0] ep_stall,
    output logic [EP_NUM-1:0] ep_sel,
    output logic [EP_NUM-1:0] ep_done,
    output logic              ep_ok
);

`ifdef USB_EPSCHED_ISO_EN
    localparam bit ISO_EN = 1'b1;
`else
    localparam bit ISO_EN = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic [3:0]        ep_q, ep_d;
    logic [1:0]        type_q, type_d;
    logic [1:0]        reply_q, reply_d;
    logic              toggle_q, toggle_d;
    logic [EP_NUM-1:0] sel_q, sel_d;
    logic [EP_NUM-1:0] done_q, done_d;
    logic              ok_q, ok_d;

    logic [EP_NUM-1:0] ep_onehot, in_tgl, out_tgl, flip_in, flip_out;
    logic              set_ep0;
    logic              ep_exists, ep_rdy, ep_stl, ep_in_tgl, ep_out_tgl, ep_iso;
    logic [1:0]        reply_dec;
    logic              toggle_dec;

    // Non-existent endpoints match no index, so they see no select, ready or stall.
    always_comb begin
        ep_onehot  = '0;
        ep_rdy     = 1'b0;
        ep_stl     = 1'b0;
        ep_in_tgl  = 1'b0;
        ep_out_tgl = 1'b0;
        for (int i = 0; i < EP_NUM; i++) begin
            if (ep_q == 4'(i)) begin
                ep_onehot[i] = 1'b1;
                ep_rdy       = ep_ready[i];
                ep_stl       = ep_stall[i];
                ep_in_tgl    = in_tgl[i];
                ep_out_tgl   = out_tgl[i];
            end
        end
    end

    assign ep_exists = |ep_onehot;
    assign ep_iso    = ISO_EN && ISO_MASK[ep_q];

    always_comb begin
        reply_dec = REPLY_ACK;
        if (!ep_exists)                reply_dec = REPLY_STALL;
        else if (type_q == TYPE_SETUP) reply_dec = (ep_q != 4'd0) ? REPLY_STALL : REPLY_ACK;
        else if (ep_iso)               reply_dec = ep_stl ? REPLY_STALL : REPLY_ACK;
        else if (ep_stl)               reply_dec = REPLY_STALL;
        else if (!ep_rdy)              reply_dec = REPLY_NAK;

        toggle_dec = 1'b0;
        if (!ep_iso && type_q == TYPE_IN)       toggle_dec = ep_in_tgl;
        else if (!ep_iso && type_q == TYPE_OUT) toggle_dec = ep_out_tgl;
    end

    always_comb begin
        state_d  = state_q;
        ep_d     = ep_q;
        type_d   = type_q;
        reply_d  = reply_q;
        toggle_d = toggle_q;
        sel_d    = sel_q;
        done_d   = '0;
        ok_d     = ok_q;
        flip_in  = '0;
        flip_out = '0;
        set_ep0  = 1'b0;

        case (state_q)
            EPS_IDLE: begin
                if (trsac.trsac_req == REQ_ACTIVE) begin
                    ep_d    = trsac.trsac_ep;
                    type_d  = trsac.trsac_type;
                    state_d = EPS_DECODE;
                end
            end
            EPS_DECODE: begin
                reply_d  = reply_dec;
                toggle_d = toggle_dec;
                sel_d    = ep_onehot;
                state_d  = EPS_ACTIVE;
            end
            EPS_ACTIVE: begin
                if (trsac.trsac_req != REQ_ACTIVE) begin
                    done_d  = ep_onehot;
                    ok_d    = (trsac.trsac_req == REQ_OK) && (reply_q == REPLY_ACK);
                    state_d = EPS_DONE;
                end
            end
            default: begin
                if (ok_q && !ep_iso) begin
                    case (type_q)
                        TYPE_IN:    flip_in  = ep_onehot;
                        TYPE_OUT:   flip_out = ep_onehot;
                        TYPE_SETUP: set_ep0  = 1'b1;
                        default:    ;
                    endcase
                end
                reply_d  = REPLY_NAK;
                toggle_d = 1'b0;
                sel_d    = '0;
                ok_d     = 1'b0;
                // A request arriving during DONE is taken now, skipping IDLE.
                if (trsac.trsac_req == REQ_ACTIVE) begin
                    ep_d    = trsac.trsac_ep;
                    type_d  = trsac.trsac_type;
                    state_d = EPS_DECODE;
                end else begin
                    state_d = EPS_IDLE;
                end
            end
        endcase

        if (!rst0_sync) begin
            state_d  = EPS_IDLE;
            ep_d     = '0;
            type_d   = TYPE_SETUP;
            reply_d  = REPLY_NAK;
            toggle_d = 1'b0;
            sel_d    = '0;
            done_d   = '0;
            ok_d     = 1'b0;
            flip_in  = '0;
            flip_out = '0;
            set_ep0  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async) begin
            state_q  <= EPS_IDLE;
            ep_q     <= '0;
            type_q   <= TYPE_SETUP;
            reply_q  <= REPLY_NAK;
            toggle_q <= 1'b0;
            sel_q    <= '0;
            done_q   <= '0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ep_q     <= ep_d;
            type_q   <= type_d;
            reply_q  <= reply_d;
            toggle_q <= toggle_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
        end
    end

    usb_eptoggle #(.EP_NUM(EP_NUM)) u_eptoggle (
        .clk      (clk),
        .rst_n    (rst0_async),
        .clr_all  (!rst0_sync),
        .flip_in  (flip_in),
        .flip_out (flip_out),
        .set_ep0  (set_ep0),
        .clr      (togglebit_rst[EP_NUM-1:0]),
        .in_tgl   (in_tgl),
        .out_tgl  (out_tgl)
    );

    assign trsac.trsac_reply  = reply_q;
    assign trsac.trsac_toggle = toggle_q;
    assign ep_sel             = sel_q;
    assign ep_done            = done_q;
    assign ep_ok              = ok_q;

endmodule

// File: doc/usb_epsched.md
Name: usb_epsched

Overview:
- Endpoint scheduler between the transaction layer and up to 16 user endpoint handlers.
- On each active transaction it decodes the endpoint and produces the ACK/NAK/STALL reply and the expected data toggle. It routes the transaction to one handler via a one-hot select and reports completion back to that handler.
- Owns the per-endpoint IN/OUT data-toggle registers, which are cleared by the standard-request block's togglebit_rst vector.

Parameters:
- EP_NUM, 16, number of implemented endpoints (1..16); endpoint indices >= EP_NUM are non-existent.
- ISO_MASK, 16'h0000, bit i=1 marks endpoint i isochronous (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst0_async  in  1  asynchronous reset, active-low
- rst0_sync  in  1  synchronous clear, active-low; same effect as reset
- trsac_req  in  2  transaction status: 0=OK, 1=ACTIVE, 2=FAIL
- trsac_type  in  2  0=SETUP, 1=OUT, 2=IN
- trsac_ep  in  4  endpoint number, valid while trsac_req=ACTIVE
- trsac_reply  out  2  0=ACK, 1=NAK, 2=STALL
- trsac_toggle  out  1  expected (OUT/SETUP) or transmitted (IN) data PID toggle
- togglebit_rst  in  16  bit i high for one cycle clears both toggles of endpoint i
- ep_ready  in  EP_NUM  handler i has buffer space (OUT) or data (IN)
- ep_stall  in  EP_NUM  handler i halted
- ep_sel  out  EP_NUM  one-hot; the handler owning the current transaction
- ep_done  out  EP_NUM  one-cycle completion pulse to handler i
- ep_ok  out  1  qualifies ep_done: 1=OK with ACK, 0=FAIL or non-ACK

Behaviour:
- Reset (async or sync): trsac_reply=NAK, trsac_toggle=0, ep_sel=0, ep_done=0, ep_ok=0, all toggles=0, state IDLE.
- States: IDLE, DECODE, ACTIVE, DONE.
- IDLE:
  - Entered when trsac_req=ACTIVE: latch trsac_ep and trsac_type, then go to DECODE.
- DECODE (exactly one cycle): register the reply, evaluated in this priority order:
  - ep >= EP_NUM -> STALL.
  - SETUP to ep!=0 -> STALL.
  - SETUP to ep0 -> ACK, regardless of ep_stall or ep_ready.
  - ep_stall[ep] -> STALL.
  - !ep_ready[ep] -> NAK.
  - otherwise -> ACK.
- DECODE outputs:
  - trsac_toggle = in-toggle[ep] for IN, out-toggle[ep] for OUT, 0 for SETUP.
  - ep_sel[ep]=1 for existing ep; ep_sel stays 0 for non-existent ep.
  - Then go to ACTIVE.
  - Reply and toggle are valid 2 cycles after trsac_req first reads ACTIVE and are held stable until DONE.
- ACTIVE: hold all outputs; when trsac_req!=ACTIVE go to DONE.
- DONE (one cycle):
  - ep_done[ep] pulses for existing ep; ep_ok=(trsac_req was OK and reply ACK).
  - If ep_ok: IN or OUT flips that direction's toggle. SETUP forces ep0 in-toggle=1 and out-toggle=1.
  - FAIL, or NAK/STALL: toggles unchanged.
  - ep_sel cleared, trsac_reply returns to NAK, go to IDLE.
  - An ACTIVE seen on the DONE cycle is not lost: it is latched and DECODE follows directly.
- togglebit_rst:
  - Applied in every state.
  - Same cycle as a DONE update of the same endpoint: the clear wins.
  - Bits >= EP_NUM are ignored.
- ep_stall or ep_ready changing after DECODE has no effect on the current reply.
- Reset mid-transaction: outputs return to reset values immediately and the transaction is abandoned with no ep_done pulse.

Optional Feature:
- Macro USB_EPSCHED_ISO_EN.
- Defined: for endpoints with ISO_MASK[i]=1, the reply is always ACK unless ep_stall[i] (then STALL); trsac_toggle=0; toggles never flip.
- Undefined: ISO_MASK is ignored and all endpoints use the bulk/interrupt rules.

Decomposition:
- Shared package usb_pkg holds:
  - REQ_OK/REQ_ACTIVE/REQ_FAIL.
  - REPLY_ACK/REPLY_NAK/REPLY_STALL.
  - TYPE_SETUP/TYPE_OUT/TYPE_IN.
  - usb_epsched state encodings.
- One sub-module, usb_eptoggle: 2xEP_NUM toggle register file with flip, set-both, and clear ports; clear has priority.

Test Plan:
- SETUP on ep0 with ep_stall[0]=1 -> reply ACK; after OK, ep0 in/out toggles=1, ep_done[0] pulses, ep_ok=1.
- OUT on ep2 with ep_ready[2]=1, toggle 0, completed OK twice -> trsac_toggle 0 then 1, and out-toggle ends at 0.
- IN on ep3 with ep_ready[3]=0 -> NAK, toggle unchanged, ep_done[3] pulse with ep_ok=0.
- IN on ep5 with ep_stall[5]=1 -> STALL. Separately, OUT to ep15 with EP_NUM=4 -> STALL, ep_sel=0, no ep_done.
- togglebit_rst=16'h0004 on the same cycle as ep2's DONE with ACK -> ep2 toggles both 0.
- FAIL mid-transfer on ep1, then rst0_async asserted during ACTIVE -> toggles unchanged after FAIL; outputs at reset values, state IDLE.
